// File: rtl/usb_gamepad_pkg.sv
// Shared constants and types for the USB gamepad report transmitter.
// Button bit positions, axis byte values and the transmit state enum.
package usb_gamepad_pkg;

   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;
   localparam int BTN_A     = 4;
   localparam int BTN_START = 11;

   localparam logic [7:0] AXIS_MIN    = 8'h00;
   localparam logic [7:0] AXIS_CENTER = 8'h80;
   localparam logic [7:0] AXIS_MAX    = 8'hFF;

   localparam int REPORT_BYTES_DEF = 8;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_HS
   } state_e;

   // Opposing directions cancel back to the centre position.
   function automatic logic [7:0] axis_byte(input logic neg,
                                            input logic pos);
      logic [7:0] b;
      b = AXIS_CENTER;
      if (neg && !pos)
         b = AXIS_MIN;
      else if (pos && !neg)
         b = AXIS_MAX;
      return b;
   endfunction

endpackage

// File: rtl/usb_gamepad_report_pack.sv
// Combinational packer: 12-bit button vector to one HID report byte.
// Byte 0 X axis, byte 1 Y axis, byte 2 buttons A..start, rest zero.
module usb_gamepad_report_pack
   import usb_gamepad_pkg::*;
#(
   parameter  int REPORT_BYTES = REPORT_BYTES_DEF,
   localparam int IW           = $clog2(REPORT_BYTES)
) (
   input  logic [11:0]   btn_i,
   input  logic [IW-1:0] idx_i,
   output logic [7:0]    byte_o
);

   // Select the report byte addressed by idx_i.
   always_comb begin
      byte_o = 8'h00;
      if (idx_i == IW'(0))
         byte_o = axis_byte(btn_i[BTN_LEFT], btn_i[BTN_RIGHT]);
      else if (idx_i == IW'(1))
         byte_o = axis_byte(btn_i[BTN_UP], btn_i[BTN_DOWN]);
      else if (idx_i == IW'(2))
         byte_o = btn_i[BTN_START:BTN_A];
   end

endmodule

// File: rtl/usb_gamepad_report_tx.sv
// Interrupt-IN endpoint: sends the gamepad report or NAKs each IN token.
// Define USB_GAMEPAD_IDLE_REPORT_EN to resend unchanged reports when idle.
module usb_gamepad_report_tx
   import usb_gamepad_pkg::*;
#(
   parameter int REPORT_BYTES = REPORT_BYTES_DEF,
   parameter int IDLE_CYCLES  = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] i_btn,
   input  logic        i_in_token,
   input  logic        i_ack,
   input  logic        i_timeout,
   input  logic        i_tx_ready,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   output logic        o_tx_last,
   output logic        o_data_pid,
   output logic        o_nak
);

   localparam int IW = $clog2(REPORT_BYTES);
   localparam logic [IW-1:0] LAST_IDX = IW'(REPORT_BYTES - 1);

   if (REPORT_BYTES < 4 || IDLE_CYCLES < 1) begin : g_bad_cfg
      $error("usb_gamepad_report_tx: invalid parameters");
   end

   state_e        state_q;
   logic [11:0]   snap_q;
   logic [11:0]   sent_q;
   logic          first_q;
   logic          retry_q;
   logic [IW-1:0] idx_q;
   logic          toggle_q;
   logic          valid_q;
   logic          last_q;
   logic          nak_q;
   logic [7:0]    pk_byte;
   logic          idle_full;

   usb_gamepad_report_pack #(
      .REPORT_BYTES(REPORT_BYTES)
   ) u_pack (
      .btn_i (snap_q),
      .idx_i (idx_q),
      .byte_o(pk_byte)
   );

`ifdef USB_GAMEPAD_IDLE_REPORT_EN
   localparam int CW = $clog2(IDLE_CYCLES + 1);
   logic [CW-1:0] idle_cnt_q;

   // Idle counter: cleared by every ACK, saturates at IDLE_CYCLES.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         idle_cnt_q <= '0;
      else if (state_q == WAIT_HS && i_ack)
         idle_cnt_q <= '0;
      else if (idle_cnt_q != CW'(IDLE_CYCLES))
         idle_cnt_q <= idle_cnt_q + CW'(1);
   end

   assign idle_full = (idle_cnt_q == CW'(IDLE_CYCLES));
`else
   assign idle_full = 1'b0;
`endif

   // Endpoint FSM: token decision, byte streaming and handshake tracking.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         snap_q   <= '0;
         sent_q   <= '0;
         first_q  <= 1'b1;
         retry_q  <= 1'b0;
         idx_q    <= '0;
         toggle_q <= 1'b0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         nak_q    <= 1'b0;
      end else begin
         nak_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (i_in_token) begin
                  if (retry_q) begin
                     state_q <= SEND;
                     valid_q <= 1'b1;
                     idx_q   <= '0;
                     last_q  <= 1'b0;
                  end else if (first_q || i_btn != sent_q || idle_full) begin
                     snap_q  <= i_btn;
                     state_q <= SEND;
                     valid_q <= 1'b1;
                     idx_q   <= '0;
                     last_q  <= 1'b0;
                  end else begin
                     nak_q <= 1'b1;
                  end
               end
            end
            SEND: begin
               if (i_tx_ready) begin
                  if (last_q) begin
                     state_q <= WAIT_HS;
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     idx_q   <= '0;
                  end else begin
                     idx_q  <= idx_q + IW'(1);
                     last_q <= (idx_q + IW'(1) == LAST_IDX);
                  end
               end
            end
            WAIT_HS: begin
               if (i_ack) begin
                  sent_q   <= snap_q;
                  first_q  <= 1'b0;
                  retry_q  <= 1'b0;
                  toggle_q <= ~toggle_q;
                  state_q  <= IDLE;
               end else if (i_timeout) begin
                  retry_q <= 1'b1;
                  state_q <= IDLE;
               end else if (i_in_token) begin
                  retry_q <= 1'b1;
                  state_q <= SEND;
                  valid_q <= 1'b1;
                  idx_q   <= '0;
                  last_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
               last_q  <= 1'b0;
            end
         endcase
      end
   end

   assign o_tx_valid = valid_q;
   assign o_tx_last  = last_q;
   assign o_tx_data  = valid_q ? pk_byte : 8'h00;
   assign o_data_pid = toggle_q;
   assign o_nak      = nak_q;

endmodule

// File: tb/tb_usb_gamepad_report_tx.sv
// Scoreboard bench for usb_gamepad_report_tx.
// Driver pushes expected bytes/NAKs; a negedge monitor pops and compares.
module tb_usb_gamepad_report_tx;

   localparam int RB = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [11:0] i_btn = '0;
   logic        i_in_token = 1'b0;
   logic        i_ack = 1'b0;
   logic        i_timeout = 1'b0;
   logic        i_tx_ready = 1'b1;
   logic [7:0]  o_tx_data;
   logic        o_tx_valid;
   logic        o_tx_last;
   logic        o_data_pid;
   logic        o_nak;

   always #5 clk = ~clk;

   usb_gamepad_report_tx #(
      .REPORT_BYTES(RB),
      .IDLE_CYCLES (1000000)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .i_btn     (i_btn),
      .i_in_token(i_in_token),
      .i_ack     (i_ack),
      .i_timeout (i_timeout),
      .i_tx_ready(i_tx_ready),
      .o_tx_data (o_tx_data),
      .o_tx_valid(o_tx_valid),
      .o_tx_last (o_tx_last),
      .o_data_pid(o_data_pid),
      .o_nak     (o_nak)
   );

   logic [11:0] ref_btn = '0;
   logic [2:0]  ref_idx = '0;
   logic [7:0]  ref_byte;

   usb_gamepad_report_pack #(
      .REPORT_BYTES(RB)
   ) u_ref (
      .btn_i (ref_btn),
      .idx_i (ref_idx),
      .byte_o(ref_byte)
   );

   typedef struct packed {
      logic       nak;
      logic [7:0] data;
      logic       last;
      logic       pid;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;
   int   bytes_acc = 0;
   int   stall_byte = -1;
   int   stall_left = 0;
   logic       prev_hold = 1'b0;
   logic [7:0] prev_data = '0;
   logic       prev_last = 1'b0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_pkt(input logic [63:0] bytes, input int n,
                           input logic pid);
      exp_t x;
      for (int i = 0; i < n; i++) begin
         x.nak  = 1'b0;
         x.data = bytes[63-8*i -: 8];
         x.last = (i == RB - 1);
         x.pid  = pid;
         q.push_back(x);
      end
   endtask

   task automatic push_nak();
      exp_t x;
      x.nak  = 1'b1;
      x.data = 8'h00;
      x.last = 1'b0;
      x.pid  = 1'b0;
      q.push_back(x);
   endtask

   // Monitor: pops one expectation per accepted byte or NAK pulse.
   initial forever begin
      @(negedge clk);
      if (!reset) begin
         bytes_acc = 0;
         prev_hold = 1'b0;
      end else begin
         if (prev_hold && o_tx_valid) begin
            chk("hold_data", o_tx_data, prev_data);
            chk("hold_last", o_tx_last, prev_last);
         end
         prev_hold = o_tx_valid && !i_tx_ready;
         prev_data = o_tx_data;
         prev_last = o_tx_last;
         if (o_nak) begin
            if (q.size() == 0) begin
               chk("unexpected_nak", 1, 0);
            end else begin
               e = q.pop_front();
               chk("nak_slot", {o_nak, o_tx_valid}, {e.nak, ~e.nak});
            end
         end
         if (o_tx_valid && i_tx_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_byte", o_tx_data, 32'hdead);
            end else begin
               e = q.pop_front();
               chk("byte_kind", o_nak, e.nak);
               chk("byte_data", o_tx_data, e.data);
               chk("byte_last", o_tx_last, e.last);
               chk("byte_pid", o_data_pid, e.pid);
            end
            bytes_acc = o_tx_last ? 0 : bytes_acc + 1;
         end
      end
   end

   // Ready driver: stalls the SIE on a chosen byte index.
   initial forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0 && o_tx_valid && bytes_acc == stall_byte) begin
         i_tx_ready = 1'b0;
         stall_left--;
      end else begin
         i_tx_ready = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic in_token(input logic exp_send);
      tick();
      i_in_token = 1'b1;
      tick();
      i_in_token = 1'b0;
      @(negedge clk);
      chk("lat_valid", o_tx_valid, exp_send);
      chk("lat_nak", o_nak, !exp_send);
   endtask

   task automatic wait_done();
      for (int n = 0; n < 64; n++) begin
         @(negedge clk);
         if (!o_tx_valid) return;
      end
      chk("packet_end_timeout", 1, 0);
   endtask

   task automatic hs(input logic a, input logic t, input logic exp_pid);
      tick();
      i_ack = a;
      i_timeout = t;
      tick();
      i_ack = 1'b0;
      i_timeout = 1'b0;
      @(negedge clk);
      chk("pid_after_hs", o_data_pid, exp_pid);
   endtask

   logic [11:0] vb[7];
   logic [63:0] vr[7];

   initial begin
      vb[0] = 12'h000; vr[0] = 64'h8080_0000_0000_0000;
      vb[1] = 12'h814; vr[1] = 64'h0080_8100_0000_0000;
      vb[2] = 12'h030; vr[2] = 64'h8080_0300_0000_0000;
      vb[3] = 12'h002; vr[3] = 64'h80FF_0000_0000_0000;
      vb[4] = 12'h00C; vr[4] = 64'h8080_0000_0000_0000;
      vb[5] = 12'h040; vr[5] = 64'h8080_0400_0000_0000;
      vb[6] = 12'h100; vr[6] = 64'h8080_1000_0000_0000;

      for (int v = 0; v < 7; v++) begin
         for (int b = 0; b < RB; b++) begin
            ref_btn = vb[v];
            ref_idx = 3'(b);
            #1;
            chk("ref_pack", ref_byte, vr[v][63-8*b -: 8]);
         end
      end

      @(negedge clk);
      chk("rst_valid", o_tx_valid, 0);
      chk("rst_last", o_tx_last, 0);
      chk("rst_nak", o_nak, 0);
      chk("rst_data", o_tx_data, 0);
      chk("rst_pid", o_data_pid, 0);
      @(negedge clk);
      reset = 1'b1;

      i_btn = 12'h000;
      push_pkt(vr[0], RB, 1'b0);
      in_token(1'b1);
      wait_done();
      hs(1'b1, 1'b0, 1'b1);

      push_nak();
      in_token(1'b0);
      @(negedge clk);
      chk("nak_no_valid", o_tx_valid, 0);

      i_btn = 12'h814;
      stall_byte = 2;
      stall_left = 3;
      push_pkt(vr[1], RB, 1'b1);
      in_token(1'b1);
      wait_done();
      hs(1'b1, 1'b0, 1'b0);

      i_btn = 12'h030;
      push_pkt(vr[2], RB, 1'b0);
      in_token(1'b1);
      wait_done();
      hs(1'b0, 1'b1, 1'b0);
      i_btn = 12'h002;
      push_pkt(vr[2], RB, 1'b0);
      in_token(1'b1);
      wait_done();
      hs(1'b1, 1'b0, 1'b1);
      push_pkt(vr[3], RB, 1'b1);
      in_token(1'b1);
      wait_done();
      hs(1'b1, 1'b0, 1'b0);

      i_btn = 12'h00C;
      push_pkt(vr[4], RB, 1'b0);
      in_token(1'b1);
      wait_done();
      hs(1'b1, 1'b1, 1'b1);
      push_nak();
      in_token(1'b0);

      i_btn = 12'h040;
      push_pkt(vr[5], RB, 1'b1);
      in_token(1'b1);
      i_btn = 12'h100;
      wait_done();
      push_pkt(vr[5], RB, 1'b1);
      in_token(1'b1);
      wait_done();
      hs(1'b1, 1'b0, 1'b0);
      push_pkt(vr[6], RB, 1'b0);
      in_token(1'b1);
      wait_done();
      hs(1'b1, 1'b0, 1'b1);

      i_btn = 12'h001;
      push_pkt(64'h8000_0000_0000_0000, 3, 1'b1);
      stall_byte = 3;
      stall_left = 1000;
      in_token(1'b1);
      begin : find_b3
         for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            if (o_tx_valid && !i_tx_ready) disable find_b3;
         end
         chk("stall_b3_timeout", 1, 0);
      end
      #2;
      reset = 1'b0;
      #1;
      chk("async_valid", o_tx_valid, 0);
      chk("async_last", o_tx_last, 0);
      chk("async_data", o_tx_data, 0);
      chk("async_pid", o_data_pid, 0);
      stall_left = 0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      i_btn = 12'h000;
      push_pkt(vr[0], RB, 1'b0);
      in_token(1'b1);
      wait_done();
      hs(1'b1, 1'b0, 1'b1);

      repeat (3) @(negedge clk);
      chk("queue_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
